// File: rtl/axis_constant_source_if.sv
// AXI-Stream master/slave bundle used by axis_constant_source.
interface axis_constant_source_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_constant_source.sv
// AXI-Stream constant generator: per-lane shadow/active registers, burst or continuous output.
// Optional macro AXIS_CONST_BEATCNT_EN exposes the beat counter as output beat_cnt.
module axis_constant_source #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      COUNT_W  = 16,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int unsigned     LANE_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  cfg_we,
  input  logic [LANE_W-1:0]     cfg_lane,
  input  logic [WIDTH-1:0]      cfg_data,
  input  logic                  cfg_commit,
  input  logic                  start,
  input  logic [COUNT_W-1:0]    len,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
`ifdef AXIS_CONST_BEATCNT_EN
  output logic [COUNT_W-1:0]    beat_cnt,
`endif
  axis_constant_source_if.master m_axis
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                             state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     active_q, active_d;
  logic [COUNT_W-1:0]                 cnt_q, cnt_d;
  logic [COUNT_W-1:0]                 len_q, len_d;
  logic                               cont_q, cont_d;
  logic                               stop_q, stop_d;
  logic                               commit_q, commit_d;
  logic                               tvalid_q, tvalid_d;
  logic                               tlast_q, tlast_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               hs_c;

  assign hs_c = tvalid_q && m_axis.tready;

  // State and datapath registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      shadow_q <= {CHANNELS{INIT_VAL}};
      active_q <= {CHANNELS{INIT_VAL}};
      cnt_q    <= '0;
      len_q    <= '0;
      cont_q   <= 1'b0;
      stop_q   <= 1'b0;
      commit_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      cont_q   <= cont_d;
      stop_q   <= stop_d;
      commit_q <= commit_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    cont_d   = cont_q;
    stop_d   = stop_q;
    commit_d = commit_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;

    // Shadow writes land first so a same-cycle start/commit picks them up
    if (cfg_we && (32'(cfg_lane) < CHANNELS)) begin
      shadow_d[cfg_lane] = cfg_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          active_d = shadow_d;
          len_d    = len;
          cont_d   = (len == COUNT_W'(0));
          cnt_d    = '0;
          stop_d   = 1'b0;
          commit_d = 1'b0;
          tvalid_d = 1'b1;
          tlast_d  = (len == COUNT_W'(1));
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (cfg_commit) commit_d = 1'b1;
        // A stop is moot once the final beat is already on the bus
        if (stop && !tlast_q) stop_d = 1'b1;

        if (hs_c) begin
          cnt_d = cnt_q + COUNT_W'(1);
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            stop_d   = 1'b0;
            commit_d = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            if (commit_q || cfg_commit) begin
              active_d = shadow_d;
              commit_d = 1'b0;
            end
            tlast_d = stop_q || stop ||
                      (!cont_q && (COUNT_W'(cnt_q + COUNT_W'(2)) == len_q));
            stop_d  = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  assign m_axis.tdata  = active_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef AXIS_CONST_BEATCNT_EN
  assign beat_cnt      = cnt_q;
`endif

endmodule

// File: tb/tb_axis_constant_source.sv
// Directed bench for axis_constant_source: vector table plus multi-cycle corner sequences.
module tb_axis_constant_source;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        cfg_we;
  logic [1:0]  cfg_lane;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic        start;
  logic [15:0] len;
  logic        stop;
  logic        tready;
  logic        busy, done, busy3, done3;
  logic [15:0] beat_cnt, beat_cnt3;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 ap_clk = ~ap_clk;

  axis_constant_source_if #(.DATA_W(32)) m_if ();
  axis_constant_source_if #(.DATA_W(24)) m3_if ();
  assign m_if.tready  = tready;
  assign m3_if.tready = tready;

  axis_constant_source #(.WIDTH(8), .CHANNELS(4), .COUNT_W(16), .INIT_VAL(8'h00)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .cfg_we(cfg_we), .cfg_lane(cfg_lane),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .start(start), .len(len),
    .stop(stop), .busy(busy), .done(done),
`ifdef AXIS_CONST_BEATCNT_EN
    .beat_cnt(beat_cnt),
`endif
    .m_axis(m_if)
  );

  // Three-lane instance: lane index 3 is out of range and INIT_VAL is non-zero
  axis_constant_source #(.WIDTH(8), .CHANNELS(3), .COUNT_W(16), .INIT_VAL(8'h05)) dut3 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .cfg_we(cfg_we), .cfg_lane(cfg_lane),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .start(start), .len(len),
    .stop(stop), .busy(busy3), .done(done3),
`ifdef AXIS_CONST_BEATCNT_EN
    .beat_cnt(beat_cnt3),
`endif
    .m_axis(m3_if)
  );

`ifndef AXIS_CONST_BEATCNT_EN
  assign beat_cnt  = '0;
  assign beat_cnt3 = '0;
`endif

  typedef struct {
    int unsigned we, lane, data, start, len, tready;
    int unsigned e_valid, e_last, e_data, e_busy, e_done;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input int unsigned we, input int unsigned lane, input int unsigned data,
                       input int unsigned commit, input int unsigned st, input int unsigned ln,
                       input int unsigned sp, input int unsigned rdy);
    cfg_we     = 1'(we);
    cfg_lane   = 2'(lane);
    cfg_data   = 8'(data);
    cfg_commit = 1'(commit);
    start      = 1'(st);
    len        = 16'(ln);
    stop       = 1'(sp);
    tready     = 1'(rdy);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input int unsigned v, input int unsigned l,
                         input int unsigned d, input int unsigned b, input int unsigned dn);
    chk({nm, ".tvalid"}, 32'(m_if.tvalid), v);
    chk({nm, ".tlast"},  32'(m_if.tlast),  l);
    chk({nm, ".tdata"},  m_if.tdata,       d);
    chk({nm, ".busy"},   32'(busy),        b);
    chk({nm, ".done"},   32'(done),        dn);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Burst len=3 with tready high, then the same burst with a stalling sink
    vecs[0]  = '{1, 0, 'h11, 0, 0, 0,  0, 0, 'h00000000, 0, 0};
    vecs[1]  = '{1, 1, 'h22, 0, 0, 0,  0, 0, 'h00000000, 0, 0};
    vecs[2]  = '{1, 2, 'h33, 0, 0, 0,  0, 0, 'h00000000, 0, 0};
    vecs[3]  = '{1, 3, 'h44, 0, 0, 0,  0, 0, 'h00000000, 0, 0};
    vecs[4]  = '{0, 0, 0,    1, 3, 1,  1, 0, 'h44332211, 1, 0};
    vecs[5]  = '{0, 0, 0,    0, 0, 1,  1, 0, 'h44332211, 1, 0};
    vecs[6]  = '{0, 0, 0,    0, 0, 1,  1, 1, 'h44332211, 1, 0};
    vecs[7]  = '{0, 0, 0,    0, 0, 1,  0, 0, 'h44332211, 0, 1};
    vecs[8]  = '{0, 0, 0,    0, 0, 1,  0, 0, 'h44332211, 0, 0};
    vecs[9]  = '{0, 0, 0,    1, 3, 1,  1, 0, 'h44332211, 1, 0};
    vecs[10] = '{0, 0, 0,    0, 0, 1,  1, 0, 'h44332211, 1, 0};
    vecs[11] = '{0, 0, 0,    0, 0, 0,  1, 0, 'h44332211, 1, 0};
    vecs[12] = '{0, 0, 0,    0, 0, 0,  1, 0, 'h44332211, 1, 0};
    vecs[13] = '{0, 0, 0,    0, 0, 1,  1, 1, 'h44332211, 1, 0};
    vecs[14] = '{0, 0, 0,    0, 0, 0,  1, 1, 'h44332211, 1, 0};
    vecs[15] = '{0, 0, 0,    0, 0, 1,  0, 0, 'h44332211, 0, 1};
    vecs[16] = '{0, 0, 0,    1, 1, 0,  0, 0, 'h44332211, 0, 0};
    vecs[17] = '{0, 0, 0,    0, 0, 0,  0, 0, 'h44332211, 0, 0};

    ap_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    step();
    step();
    chk_out("reset", 0, 0, 'h00000000, 0, 0);
    chk("reset.dut3.tdata", 32'(m3_if.tdata), 'h050505);
    chk("reset.beat_cnt", 32'(beat_cnt), 0);
    ap_rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].we, vecs[i].lane, vecs[i].data, 0, vecs[i].start, vecs[i].len, 0,
            vecs[i].tready);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_last, vecs[i].e_data,
              vecs[i].e_busy, vecs[i].e_done);
    end
    chk("dut3.lane3_ignored", 32'(m3_if.tdata), 'h332211);

    // Continuous stream, commit requested while stalled
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    step();
    chk_out("cont.first", 1, 0, 'h44332211, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
    end
    chk_out("cont.beat6", 1, 0, 'h44332211, 1, 0);
    drive(1, 2, 'hAA, 1, 0, 0, 0, 0);
    step();
    chk_out("commit.stall1", 1, 0, 'h44332211, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("commit.stall2", 1, 0, 'h44332211, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk_out("commit.applied", 1, 0, 'h44AA2211, 1, 0);

    // Stop while stalled: current beat untouched, next beat is last
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk_out("stop.held", 1, 0, 'h44AA2211, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk_out("stop.lastbeat", 1, 1, 'h44AA2211, 1, 0);
    step();
    chk_out("stop.done", 0, 0, 'h44AA2211, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("stop.idle", 0, 0, 'h44AA2211, 0, 0);
`ifdef AXIS_CONST_BEATCNT_EN
    chk("stop.beat_cnt", 32'(beat_cnt), 8);
`endif

    // Reset in the middle of a stalled burst
    drive(0, 0, 0, 0, 1, 10, 0, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_out("rst.beat4", 1, 0, 'h44AA2211, 1, 0);
    ap_rst = 1'b1;
    step();
    chk_out("rst.abandon", 0, 0, 'h00000000, 0, 0);
    chk("rst.dut3.tdata", 32'(m3_if.tdata), 'h050505);
    chk("rst.beat_cnt", 32'(beat_cnt), 0);
    ap_rst = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    step();
    chk_out("init.beat", 1, 1, 'h00000000, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk_out("init.done", 0, 0, 'h00000000, 0, 1);
    step();

    // Same-cycle write with start; lane 3 is valid on dut, out of range on dut3
    drive(1, 3, 'hEE, 0, 1, 1, 0, 0);
    step();
    chk_out("oor.beat", 1, 1, 'hEE000000, 1, 0);
    chk("oor.dut3.tdata", 32'(m3_if.tdata), 'h050505);
    chk("oor.dut3.tlast", 32'(m3_if.tlast), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk_out("oor.done", 0, 0, 'hEE000000, 0, 1);
    chk("oor.dut3.done", 32'(done3), 1);
`ifdef AXIS_CONST_BEATCNT_EN
    chk("oor.beat_cnt", 32'(beat_cnt), 1);
    chk("oor.dut3.beat_cnt", 32'(beat_cnt3), 1);
`endif
    step();
    chk("oor.dut3.busy", 32'(busy3), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
